// File: rtl/popcount_seq_pkg.sv
// Shared types and helpers for the popcount sequencer and its chain datapath.
package popcount_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} popcount_seq_state_e;

    function automatic int cnt_w(int n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/popcount_seq_if.sv
// Row-in / result-out handshake bundle for popcount_seq.
interface popcount_seq_if
    import popcount_pkg::*;
#(
    parameter int MAX_N = 64,
    parameter int MAX_W = $clog2(MAX_N + 1),
    parameter int ACC_W = 32
);
    localparam int MAX_N_W = cnt_w(MAX_N);

    logic               in_valid;
    logic               in_ready;
    logic [MAX_N-1:0]   in_bits;
    logic [MAX_N_W-1:0] in_n;
    logic [MAX_W-1:0]   in_k;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic               out_found;
    logic [MAX_N_W-1:0] out_index;
    logic [MAX_W-1:0]   out_total;
    logic [ACC_W-1:0]   out_acc;
    logic               out_last;

    modport slave (
        input  in_valid, in_bits, in_n, in_k, in_last, out_ready,
        output in_ready, out_valid, out_found, out_index, out_total, out_acc, out_last
    );

    modport master (
        output in_valid, in_bits, in_n, in_k, in_last, out_ready,
        input  in_ready, out_valid, out_found, out_index, out_total, out_acc, out_last
    );

endinterface

// File: rtl/popcount_seq_chain.sv
// Prefix popcount chain: o_chain[i] counts ones among the first i row bits (MSB first).
// Positions beyond i_n contribute nothing, so o_chain holds flat above n.
module popcount_chain
    import popcount_pkg::*;
#(
    parameter int MAX_N = 64,
    parameter int MAX_W = $clog2(MAX_N + 1)
) (
    input  logic [MAX_N-1:0]             i_bits,
    input  logic [cnt_w(MAX_N)-1:0]      i_n,
    output logic [MAX_N:0][MAX_W-1:0]    o_chain
);
    localparam int MAX_N_W = cnt_w(MAX_N);

    logic [MAX_W-1:0] w_run;

    always_comb begin
        w_run      = '0;
        o_chain[0] = '0;
        for (int i = 1; i <= MAX_N; i++) begin
            w_run      = w_run + MAX_W'(i_bits[MAX_N-i] & (MAX_N_W'(i) <= i_n));
            o_chain[i] = w_run;
        end
    end

endmodule

// File: rtl/popcount_seq.sv
// Sequencer: latches a row, walks prefix positions to find the first count == k,
// and reports position, row total and the running group sum.
module popcount_seq
    import popcount_pkg::*;
#(
    parameter int MAX_N = 64,
    parameter int MAX_W = $clog2(MAX_N + 1),
    parameter int ACC_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    popcount_seq_if.slave bus
);
    localparam int MAX_N_W = cnt_w(MAX_N);

    if (MAX_W < $clog2(MAX_N + 1)) begin : g_chk_w
        $error("popcount_seq: MAX_W too narrow for MAX_N");
    end

    popcount_seq_state_e r_state;
    logic [MAX_N-1:0]    r_bits;
    logic [MAX_N_W-1:0]  r_n;
    logic [MAX_W-1:0]    r_k;
    logic                r_last;
    logic [MAX_N_W-1:0]  r_idx;
    logic [ACC_W-1:0]    r_acc;
    logic                r_found;
    logic [MAX_N_W-1:0]  r_index;
    logic [MAX_W-1:0]    r_total;
    logic [ACC_W-1:0]    r_out_acc;
    logic                r_out_last;

    logic [MAX_N:0][MAX_W-1:0] w_chain;
    logic [MAX_N_W-1:0]        w_n_clamp;
    logic                      w_hit;
    logic [MAX_W-1:0]          w_total;

    popcount_chain #(.MAX_N(MAX_N), .MAX_W(MAX_W)) u_chain (
        .i_bits  (r_bits),
        .i_n     (r_n),
        .o_chain (w_chain)
    );

    assign w_n_clamp = (bus.in_n > MAX_N_W'(MAX_N)) ? MAX_N_W'(MAX_N) : bus.in_n;
    // r_idx never passes r_n, so entries above n are never looked at.
    assign w_hit     = (w_chain[r_idx] == r_k);
    assign w_total   = w_chain[r_n];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bits     <= '0;
            r_n        <= '0;
            r_k        <= '0;
            r_last     <= 1'b0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_found    <= 1'b0;
            r_index    <= '0;
            r_total    <= '0;
            r_out_acc  <= '0;
            r_out_last <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_bits  <= bus.in_bits;
                    r_n     <= w_n_clamp;
                    r_k     <= bus.in_k;
                    r_last  <= bus.in_last;
                    r_idx   <= '0;
                    r_state <= S_SCAN;
                end
                S_SCAN: if (w_hit || r_idx == r_n) begin
                    r_found    <= w_hit;
                    r_index    <= w_hit ? r_idx : '0;
                    r_total    <= w_total;
                    r_out_acc  <= r_acc + ACC_W'(w_total);
                    r_out_last <= r_last;
                    r_state    <= S_DONE;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
                // Group sum only commits once the consumer has taken the row.
                S_DONE: if (bus.out_ready) begin
                    r_acc   <= r_last ? '0 : r_out_acc;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_found = r_found;
    assign bus.out_index = r_index;
    assign bus.out_total = r_total;
    assign bus.out_acc   = r_out_acc;
    assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_popcount_seq.sv
// Bench for popcount_seq at MAX_N=8: vector table, corner sequences, random rows vs a model.
module tb_popcount_seq;
    import popcount_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    popcount_seq_if #(.MAX_N(8), .MAX_W(4), .ACC_W(32)) bus ();
    popcount_seq #(.MAX_N(8), .MAX_W(4), .ACC_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic        found;
        logic [3:0]  idx;
        logic [3:0]  tot;
        logic [31:0] acc;
        logic        last;
        int          lat;
    } exp_t;

    typedef struct {
        logic [7:0] bits;
        logic [3:0] n;
        logic [3:0] k;
        logic       last;
        exp_t       e;
    } vec_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] tb_acc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [3:0] n, input logic [3:0] k,
                        input logic last, input exp_t e);
        int w = 0;
        while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
        chk("in_ready_before_send", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1; bus.in_bits = b; bus.in_n = n; bus.in_k = k; bus.in_last = last;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        q.push_back(e);
    endtask

    task automatic recv(input bit do_hs, output exp_t e);
        int n = 1;
        while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (q.size() == 0) begin
            chk("queue_nonempty", 0, 1);
            e = '{1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 0};
        end else begin
            e = q.pop_front();
            chk("latency", n, e.lat);
            chk("out_valid", 32'(bus.out_valid), 1);
            chk("out_found", 32'(bus.out_found), 32'(e.found));
            chk("out_index", 32'(bus.out_index), 32'(e.idx));
            chk("out_total", 32'(bus.out_total), 32'(e.tot));
            chk("out_acc", bus.out_acc, e.acc);
            chk("out_last", 32'(bus.out_last), 32'(e.last));
            chk("in_ready_done", 32'(bus.in_ready), 0);
        end
        if (do_hs) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            chk("idle_after_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
            tb_acc = e.last ? 32'd0 : e.acc;
        end
    endtask

    function automatic exp_t model(input logic [7:0] b, input logic [3:0] n, input logic [3:0] k,
                                   input logic last, input logic [31:0] acc);
        exp_t r;
        int   nn = (n > 8) ? 8 : int'(n);
        int   cnt = 0;
        r = '{1'b0, 4'd0, 4'd0, 32'd0, last, 0};
        for (int i = 0; i <= nn; i++) begin
            if (i > 0) cnt += int'(b[8-i]);
            if (!r.found && cnt == int'(k)) begin r.found = 1'b1; r.idx = 4'(i); end
        end
        r.tot = 4'(cnt);
        r.acc = acc + 32'(cnt);
        r.lat = r.found ? int'(r.idx) + 2 : nn + 2;
        return r;
    endfunction

    vec_t tbl[8];

    initial begin
        exp_t e;
        int   stale;
        tbl[0] = '{8'b1011_0010, 4'd8,  4'd3, 1'b0, '{1'b1, 4'd4, 4'd4, 32'd4,  1'b0, 6}};
        tbl[1] = '{8'b1011_0010, 4'd5,  4'd4, 1'b0, '{1'b0, 4'd0, 4'd3, 32'd7,  1'b0, 7}};
        tbl[2] = '{8'hFF,        4'd8,  4'd0, 1'b1, '{1'b1, 4'd0, 4'd8, 32'd15, 1'b1, 2}};
        tbl[3] = '{8'hFF,        4'd12, 4'd0, 1'b0, '{1'b1, 4'd0, 4'd8, 32'd8,  1'b0, 2}};
        tbl[4] = '{8'hFF,        4'd0,  4'd1, 1'b1, '{1'b0, 4'd0, 4'd0, 32'd8,  1'b1, 2}};
        tbl[5] = '{8'h0F,        4'd4,  4'd5, 1'b0, '{1'b0, 4'd0, 4'd0, 32'd0,  1'b0, 6}};
        tbl[6] = '{8'h0F,        4'd8,  4'd4, 1'b0, '{1'b1, 4'd8, 4'd4, 32'd4,  1'b0, 10}};
        tbl[7] = '{8'h80,        4'd1,  4'd1, 1'b1, '{1'b1, 4'd1, 4'd1, 32'd5,  1'b1, 3}};

        bus.in_valid = 1'b0; bus.in_bits = '0; bus.in_n = '0; bus.in_k = '0;
        bus.in_last = 1'b0; bus.out_ready = 1'b0;
        #3;
        chk("rst_outputs", {bus.out_valid, bus.out_found, bus.out_index, bus.out_total, bus.out_last}, 0);
        chk("rst_acc", bus.out_acc, 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            send(tbl[i].bits, tbl[i].n, tbl[i].k, tbl[i].last, tbl[i].e);
            recv(1'b1, e);
        end

        // Stall in DONE with a competing row offered; nothing may move.
        send(8'b1011_0010, 4'd8, 4'd2, 1'b0, '{1'b1, 4'd3, 4'd4, 32'd4, 1'b0, 5});
        recv(1'b0, e);
        bus.in_valid = 1'b1; bus.in_bits = 8'h01; bus.in_n = 4'd8; bus.in_k = 4'd1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("hold_valid_ready", {30'd0, bus.out_valid, bus.in_ready}, 32'b10);
            chk("hold_data", {bus.out_found, bus.out_index, bus.out_total, bus.out_last},
                {e.found, e.idx, e.tot, e.last});
            chk("hold_acc", bus.out_acc, e.acc);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("release_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
        tb_acc = e.acc;
        send(8'hAA, 4'd8, 4'd8, 1'b1, '{1'b0, 4'd0, 4'd4, 32'd8, 1'b1, 10});
        recv(1'b1, e);

        // Reset in the middle of a scan, with a non-zero group sum pending.
        send(8'hF0, 4'd8, 4'd1, 1'b0, '{1'b1, 4'd1, 4'd4, 32'd4, 1'b0, 3});
        recv(1'b1, e);
        send(8'hFF, 4'd8, 4'd8, 1'b0, '{1'b1, 4'd8, 4'd8, 32'd12, 1'b0, 10});
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {bus.out_valid, bus.out_found, bus.out_index, bus.out_total, bus.out_last}, 0);
        chk("midrst_acc", bus.out_acc, 0);
        chk("midrst_in_ready", 32'(bus.in_ready), 1);
        q.delete();
        tb_acc = 0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        stale = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus.out_valid) stale++;
            @(posedge clk); #1;
        end
        chk("no_stale_result", stale, 0);
        send(8'hE0, 4'd8, 4'd3, 1'b0, '{1'b1, 4'd3, 4'd3, 32'd3, 1'b0, 5});
        recv(1'b1, e);

        for (int r = 0; r < 12; r++) begin
            logic [7:0] b;
            logic [3:0] n;
            logic [3:0] k;
            logic       l;
            b = 8'($urandom);
            n = 4'($urandom_range(0, 10));
            k = 4'($urandom_range(0, 9));
            l = 1'($urandom_range(0, 1));
            send(b, n, k, l, model(b, n, k, l, tb_acc));
            recv(1'b1, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/popcount_seq.md
Name: popcount_seq

Overview:
- Sequencing controller around the existing `popcount_chain` datapath.
- Accepts one bit-row per valid/ready handshake, latches it, and drives the chain combinationally from the latched row.
- Walks prefix positions one per cycle to find the first position where the running popcount equals a target `k`. Reports the position and the row total.
- Keeps a running sum of row totals across a group of rows; a group ends on a row flagged `last`.

Parameters:
- MAX_N, 64, maximum row length in bits.
- MAX_W, $clog2(MAX_N+1), width of prefix counts. Elaboration `$error` if less than $clog2(MAX_N+1).
- MAX_N_W, (MAX_N<=1)?1:$clog2(MAX_N+1), width of `n` and of indices.
- ACC_W, 32, width of the group accumulator.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  row offered.
- in_ready  output  1  block can accept a row.
- in_bits  input  MAX_N  row bits; bit MAX_N-1 is position 1 (MSB-first).
- in_n  input  MAX_N_W  row length; values > MAX_N are clamped to MAX_N.
- in_k  input  MAX_W  target prefix count.
- in_last  input  1  row closes the current group.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_found  output  1  a prefix position with count == k exists.
- out_index  output  MAX_N_W  first position i (0..n) with chain[i]==k; 0 when not found.
- out_total  output  MAX_W  popcount of the first n bits (chain[n]).
- out_acc  output  ACC_W  sum of out_total over the group so far, including this row.
- out_last  output  1  echo of in_last.

Behaviour:
- Reset (async assert, sync deassert at the flop level):
  - state = IDLE; row, n, k, last and index counter cleared; accumulator = 0.
  - All outputs 0, except in_ready = 1 once state is IDLE.
  - Reset mid-SCAN or mid-DONE drops the row and its result, with no partial output.
- States:
  - IDLE:
    - in_ready = 1 and out_valid = 0.
    - On in_valid: latch bits, clamped n, k and last; set i = 0; go to SCAN.
  - SCAN:
    - in_ready = 0.
    - Each cycle compare chain[i] against k, using only i <= n; chain entries above n are never sampled.
    - If chain[i]==k: found = 1, index = i, go to DONE.
    - Else if i==n: found = 0, index = 0, go to DONE.
    - Else i++.
  - DONE:
    - out_valid = 1 and in_ready = 0. Outputs are registered and stable until the handshake.
    - On out_ready: if last, accumulator clears to 0 after the handshake; state goes to IDLE.
    - No accept occurs in the same cycle as the out handshake.
- Total and accumulator:
  - total = chain[n], captured on the SCAN→DONE transition.
  - out_acc = accumulator + total is registered at the same point and wraps modulo 2^ACC_W.
- Latency:
  - Accept at cycle T gives out_valid at T+index+2 when found, and at T+n+2 when not found.
  - Minimum throughput is one row per (scan length + 3) cycles.
- Boundaries:
  - k==0 gives found at index 0 (chain[0]==0).
  - k > n is never found and runs the full scan.
  - n==0 is a single SCAN cycle with total 0.
  - The chain is monotone in steps of 0/1, so the first equality is also the first position with count >= k.
  - in_valid held during SCAN/DONE is ignored. The producer keeps data stable until in_ready.
  - out_ready while not out_valid has no effect.

Decomposition:
- Package `popcount_pkg` holds:
  - typedef enum logic [1:0] popcount_seq_state_e {S_IDLE, S_SCAN, S_DONE};
  - function cnt_w(int n) returning (n<=1)?1:$clog2(n+1).
- The single sub-module is the existing `popcount_chain`, instantiated with the latched row and n.
- The scan counter, compare and accumulator stay inline.

Test Plan:
- MAX_N=8, bits=8'b1011_0010, n=8, k=3 -> found=1, index=4, total=4, out_valid 6 cycles after accept.
- Same bits, n=5, k=4 -> found=0, index=0, total=3, latency 7.
- bits=8'hFF, n=8, k=0 -> found=1, index=0, total=8, latency 2. Also in_n=12 -> clamped to 8, total=8.
- Group of rows with totals 4, 3, 8, last on the third -> out_acc 4, 7, 15. The next row's out_acc equals its own total.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0. Release -> IDLE next cycle, accept the cycle after.
- Assert rst_n=0 at SCAN i=2 -> all outputs 0 immediately. After release, in_ready=1 and the accumulator is 0; no stale result appears.
